// File: rtl/p1v_clk_pkg.sv
// Shared definitions for the CLK configuration path: sequencer state type,
// CLK register bit positions, reset value and the settle-decision helper.
package p1v_clk_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_QUIESCE = 3'd1,
        ST_APPLY   = 3'd2,
        ST_SETTLE  = 3'd3,
        ST_RELEASE = 3'd4,
        ST_SRESET  = 3'd5
    } clkseq_state_t;

    localparam int CLK_RESET   = 7;
    localparam int CLK_PLLENA  = 6;
    localparam int CLK_OSCENA  = 5;
    localparam int CLK_OSCM_HI = 4;
    localparam int CLK_OSCM_LO = 3;

    localparam logic [6:0] CFG_RESET_VAL = 7'h00;

    // True when moving from old_cfg to new_cfg starts the PLL or oscillator,
    // or retunes the oscillator mode while the oscillator is running.
    function automatic logic clk_needs_settle(input logic [6:0] old_cfg,
                                              input logic [6:0] new_cfg);
        logic pll_on;
        logic osc_on;
        logic mode_chg;
        pll_on   = !old_cfg[CLK_PLLENA] && new_cfg[CLK_PLLENA];
        osc_on   = !old_cfg[CLK_OSCENA] && new_cfg[CLK_OSCENA];
        mode_chg = new_cfg[CLK_OSCENA] &&
                   (old_cfg[CLK_OSCM_HI:CLK_OSCM_LO] != new_cfg[CLK_OSCM_HI:CLK_OSCM_LO]);
        return pll_on || osc_on || mode_chg;
    endfunction

endpackage

// File: rtl/clk_cfg_sequencer.sv
// Sequences CLK configuration changes toward the clock generator: stalls the
// cogs, applies the new mode, waits for oscillator/PLL settle, then releases.
// A request with the RESET bit set produces a timed soft-reset pulse instead.
module clk_cfg_sequencer
    import p1v_clk_pkg::*;
#(
    parameter int QUIESCE_CYCLES = 4,
    parameter int SETTLE_CYCLES  = 1600,
    parameter int RESET_CYCLES   = 16
) (
    input  logic       clock_160,
    input  logic       nres,
    input  logic [7:0] cfg_req,
    output logic [6:0] cfg_out,
    output logic       cog_hold,
    output logic       soft_res,
    output logic       busy
);

    // A zero-length phase still occupies one cycle.
    localparam int Q_EFF = (QUIESCE_CYCLES < 1) ? 1 : QUIESCE_CYCLES;
    localparam int S_EFF = (SETTLE_CYCLES  < 1) ? 1 : SETTLE_CYCLES;
    localparam int R_EFF = (RESET_CYCLES   < 1) ? 1 : RESET_CYCLES;
    localparam int MAX_QS = (Q_EFF > S_EFF) ? Q_EFF : S_EFF;
    localparam int MAX_N  = (MAX_QS > R_EFF) ? MAX_QS : R_EFF;
    localparam int CNT_W  = $clog2(MAX_N) + 1;

    localparam logic [CNT_W-1:0] Q_LOAD  = CNT_W'(Q_EFF - 1);
    localparam logic [CNT_W-1:0] S_LOAD  = CNT_W'(S_EFF - 1);
    localparam logic [CNT_W-1:0] R_LOAD  = CNT_W'(R_EFF - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    clkseq_state_t    r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [6:0]       r_pending;
    logic [6:0]       r_cfg_out;
    logic             r_need_settle;
    logic             r_cog_hold;
    logic             r_soft_res;
    logic             r_busy;

    assign cfg_out  = r_cfg_out;
    assign cog_hold = r_cog_hold;
    assign soft_res = r_soft_res;
    assign busy     = r_busy;

    // Sequencer FSM; every output is registered and set on the state transition.
    always_ff @(posedge clock_160) begin
        if (!nres) begin
            r_state       <= ST_IDLE;
            r_cnt         <= CNT_ZERO;
            r_pending     <= CFG_RESET_VAL;
            r_cfg_out     <= CFG_RESET_VAL;
            r_need_settle <= 1'b0;
            r_cog_hold    <= 1'b0;
            r_soft_res    <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cfg_req[CLK_RESET]) begin
                        r_state    <= ST_SRESET;
                        r_cnt      <= R_LOAD;
                        r_cfg_out  <= CFG_RESET_VAL;
                        r_soft_res <= 1'b1;
                        r_busy     <= 1'b1;
                    end else if (cfg_req[6:0] != r_cfg_out) begin
                        r_state    <= ST_QUIESCE;
                        r_cnt      <= Q_LOAD;
                        r_pending  <= cfg_req[6:0];
                        r_cog_hold <= 1'b1;
                        r_busy     <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_QUIESCE: begin
                    if (r_cnt == CNT_ZERO) begin
                        // Decide on settle against the configuration being replaced.
                        r_state       <= ST_APPLY;
                        r_cfg_out     <= r_pending;
                        r_need_settle <= clk_needs_settle(r_cfg_out, r_pending);
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                ST_APPLY: begin
                    if (r_need_settle) begin
                        r_state <= ST_SETTLE;
                        r_cnt   <= S_LOAD;
                    end else begin
                        r_state    <= ST_RELEASE;
                        r_cog_hold <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    if (r_cnt == CNT_ZERO) begin
                        r_state    <= ST_RELEASE;
                        r_cog_hold <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                ST_RELEASE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                ST_SRESET: begin
                    if (r_cnt == CNT_ZERO) begin
                        r_state    <= ST_IDLE;
                        r_soft_res <= 1'b0;
                        r_busy     <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                default: begin
                    r_state       <= ST_IDLE;
                    r_cnt         <= CNT_ZERO;
                    r_cfg_out     <= CFG_RESET_VAL;
                    r_need_settle <= 1'b0;
                    r_cog_hold    <= 1'b0;
                    r_soft_res    <= 1'b0;
                    r_busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule
